// File: rtl/muldiv_if.sv
// Request/response bundle between the multicycle control unit and muldiv_unit.
// The control side drives the master modport; the engine takes the slave modport.
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hilo_we;
  logic             hilo_sel;
  logic [WIDTH-1:0] hilo_wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hilo_we, hilo_sel, hilo_wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, a, b, hilo_we, hilo_sel, hilo_wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide engine with HI/LO registers.
// Define MULDIV_EARLY_EXIT_EN to end MUL once the remaining multiplier is zero.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic      clock,
  input  logic      reset,
  muldiv_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? (~v) + WIDTH'(1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] fix_sign(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? (~v) + (2*WIDTH)'(1) : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               dz_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] prod_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvsr_q;
  logic               neg_q;
  logic               rneg_q;
  logic               op_div_q;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic               is_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               accept, div_by_zero;
  logic [WIDTH-1:0]   mplier_nxt;
  logic [WIDTH:0]     trial;
  logic [2*WIDTH-1:0] prod_fix, quo_fix, rem_fix;

  assign a_s         = bus.a;
  assign b_s         = bus.b;
  assign is_signed   = ~bus.op[0];
  assign a_neg       = is_signed && (a_s < 0);
  assign b_neg       = is_signed && (b_s < 0);
  assign mag_a       = magnitude(bus.a, a_neg);
  assign mag_b       = magnitude(bus.b, b_neg);
  assign accept      = bus.start && (state_q == IDLE);
  assign div_by_zero = bus.op[1] && (bus.b == '0);
  assign mplier_nxt  = mplier_q >> 1;

  // Restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};

  always_comb begin
    prod_fix = fix_sign(prod_q, neg_q);
    quo_fix  = fix_sign({{WIDTH{1'b0}}, quo_q}, neg_q);
    rem_fix  = fix_sign({{WIDTH{1'b0}}, rem_q}, rneg_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (div_by_zero)    state_d = FIX;
          else if (bus.op[1]) state_d = DIV;
`ifdef MULDIV_EARLY_EXIT_EN
          else if (mag_b == '0) state_d = FIX;
`endif
          else                state_d = MUL;
        end
      end
      MUL: begin
`ifdef MULDIV_EARLY_EXIT_EN
        if (cnt_q == CNT_W'(1) || mplier_nxt == '0) state_d = FIX;
`else
        if (cnt_q == CNT_W'(1)) state_d = FIX;
`endif
      end
      DIV:     if (cnt_q == CNT_W'(1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dz_q       <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      done_q     <= (state_q == FIX);
      div_zero_q <= (state_q == FIX) && dz_q;
      if (accept) begin
        cnt_q <= CNT_W'(WIDTH);
        dz_q  <= div_by_zero;
      end else if (state_q == MUL || state_q == DIV) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      // A direct write in the accept cycle lands first; the FIX write later replaces it.
      if (state_q == FIX && !dz_q) begin
        if (op_div_q) begin
          hi_q <= rem_fix[WIDTH-1:0];
          lo_q <= quo_fix[WIDTH-1:0];
        end else begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
      end else if (state_q == IDLE && bus.hilo_we) begin
        if (bus.hilo_sel) hi_q <= bus.hilo_wdata;
        else              lo_q <= bus.hilo_wdata;
      end
    end
  end

  // Iteration datapath; only meaningful between accept and FIX, so it carries no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      mcand_q  <= {{WIDTH{1'b0}}, mag_a};
      mplier_q <= mag_b;
      prod_q   <= '0;
      quo_q    <= mag_a;
      rem_q    <= '0;
      dvsr_q   <= mag_b;
      neg_q    <= a_neg ^ b_neg;
      rneg_q   <= a_neg;
      op_div_q <= bus.op[1];
    end else if (state_q == MUL) begin
      if (mplier_q[0]) prod_q <= prod_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_nxt;
    end else if (state_q == DIV) begin
      if (!trial[WIDTH]) begin
        rem_q <= trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_q <= {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        quo_q <= {quo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at WIDTH=32 (fixed or early-exit build).
module tb_muldiv_unit;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_if #(.WIDTH(32)) bus ();

  muldiv_unit #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

`ifdef MULDIV_EARLY_EXIT_EN
  localparam int LAT_SMALL = 4;
`else
  localparam int LAT_SMALL = 33;
`endif
  localparam int LAT_FULL = 33;

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int from, output int cycles, output bit busy_ok);
    cycles  = from;
    busy_ok = 1'b1;
    do begin
      @(posedge clock); #1;
      cycles++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
      if (bus.done && bus.busy)   busy_ok = 1'b0;
    end while (!bus.done && cycles < 200);
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", bus.done); end
    vectors++; if (bus.div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dz: got %b want 0", bus.div_zero); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL reset_lo: got %h want 0", bus.lo); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mult;
    int cyc; bit bok;
    start_op(2'b00, 32'hFFFFFFFD, 32'd7);
    wait_done(0, cyc, bok);
    vectors++; if (cyc !== LAT_SMALL) begin miscompares++; $display("FAIL mult_latency: got %0d want %0d", cyc, LAT_SMALL); end
    vectors++; if (!bok) begin miscompares++; $display("FAIL mult_busy: got 0 want 1 during op"); end
    vectors++; if (bus.hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL mult_hi: got %h want FFFFFFFF", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFFFFEB) begin miscompares++; $display("FAIL mult_lo: got %h want FFFFFFEB", bus.lo); end
    vectors++; if (bus.div_zero !== 1'b0) begin miscompares++; $display("FAIL mult_dz: got %b want 0", bus.div_zero); end
    @(posedge clock); #1;
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL mult_done_width: got %b want 0", bus.done); end
  endtask

  task automatic test_back_to_back;
    int cyc; bit bok;
    start_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, cyc, bok);
    vectors++; if (cyc !== LAT_FULL) begin miscompares++; $display("FAIL multu_latency: got %0d want %0d", cyc, LAT_FULL); end
    vectors++; if (bus.hi !== 32'hFFFFFFFE) begin miscompares++; $display("FAIL multu_hi: got %h want FFFFFFFE", bus.hi); end
    vectors++; if (bus.lo !== 32'h00000001) begin miscompares++; $display("FAIL multu_lo: got %h want 00000001", bus.lo); end
    // Issue the next request in the done cycle.
    start_op(2'b11, 32'd7, 32'd2);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept: busy got %b want 1", bus.busy); end
    wait_done(0, cyc, bok);
    vectors++; if (cyc !== LAT_FULL) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", cyc, LAT_FULL); end
    vectors++; if (!bok) begin miscompares++; $display("FAIL b2b_busy: got 0 want 1 during op"); end
    vectors++; if (bus.lo !== 32'd3) begin miscompares++; $display("FAIL divu_lo: got %h want 3", bus.lo); end
    vectors++; if (bus.hi !== 32'd1) begin miscompares++; $display("FAIL divu_hi: got %h want 1", bus.hi); end
  endtask

  task automatic test_div;
    int cyc; bit bok;
    logic [1:0]  ops  [4] = '{2'b10, 2'b10, 2'b10, 2'b11};
    logic [31:0] as   [4] = '{32'hFFFFFFF9, 32'h80000000, 32'd7,        32'hFFFFFFFF};
    logic [31:0] bs   [4] = '{32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000010};
    logic [31:0] qexp [4] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFD, 32'h0FFFFFFF};
    logic [31:0] rexp [4] = '{32'hFFFFFFFF, 32'h00000000, 32'h00000001, 32'h0000000F};
    for (int i = 0; i < 4; i++) begin
      start_op(ops[i], as[i], bs[i]);
      wait_done(0, cyc, bok);
      vectors++; if (cyc !== LAT_FULL) begin miscompares++; $display("FAIL div%0d_latency: got %0d want %0d", i, cyc, LAT_FULL); end
      vectors++; if (bus.lo !== qexp[i]) begin miscompares++; $display("FAIL div%0d_lo: got %h want %h", i, bus.lo, qexp[i]); end
      vectors++; if (bus.hi !== rexp[i]) begin miscompares++; $display("FAIL div%0d_hi: got %h want %h", i, bus.hi, rexp[i]); end
      vectors++; if (bus.div_zero !== 1'b0) begin miscompares++; $display("FAIL div%0d_dz: got %b want 0", i, bus.div_zero); end
    end
  endtask

  task automatic test_div_zero;
    int cyc; bit bok;
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'h1234;
    @(posedge clock); #1;
    bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'h5678;
    @(posedge clock); #1;
    bus.hilo_we = 1'b0;
    vectors++; if (bus.hi !== 32'h1234) begin miscompares++; $display("FAIL preload_hi: got %h want 1234", bus.hi); end
    vectors++; if (bus.lo !== 32'h5678) begin miscompares++; $display("FAIL preload_lo: got %h want 5678", bus.lo); end
    start_op(2'b10, 32'd99, 32'd0);
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL dz_busy: got %b want 1", bus.busy); end
    wait_done(0, cyc, bok);
    vectors++; if (cyc !== 1) begin miscompares++; $display("FAIL dz_latency: got %0d want 1", cyc); end
    vectors++; if (bus.div_zero !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b want 1", bus.div_zero); end
    vectors++; if (bus.hi !== 32'h1234) begin miscompares++; $display("FAIL dz_hi: got %h want 1234", bus.hi); end
    vectors++; if (bus.lo !== 32'h5678) begin miscompares++; $display("FAIL dz_lo: got %h want 5678", bus.lo); end
    @(posedge clock); #1;
    vectors++; if (bus.div_zero !== 1'b0) begin miscompares++; $display("FAIL dz_width: got %b want 0", bus.div_zero); end
    // Direct write on the same edge as an accepted start; a zero divide leaves it visible.
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'hA5A5A5A5;
    start_op(2'b11, 32'd5, 32'd0);
    bus.hilo_we = 1'b0;
    wait_done(0, cyc, bok);
    vectors++; if (bus.lo !== 32'hA5A5A5A5) begin miscompares++; $display("FAIL we_with_start_lo: got %h want A5A5A5A5", bus.lo); end
    vectors++; if (bus.hi !== 32'h1234) begin miscompares++; $display("FAIL we_with_start_hi: got %h want 1234", bus.hi); end
  endtask

  task automatic test_ignore_while_busy;
    int cyc; bit bok;
    start_op(2'b00, 32'd100, 32'hFFFFFFFB);
    @(posedge clock); #1;
    bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd1; bus.b = 32'd1;
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b0; bus.hilo_wdata = 32'hDEADBEEF;
    @(posedge clock); #1;
    bus.start = 1'b0; bus.hilo_we = 1'b0;
    vectors++; if (bus.lo === 32'hDEADBEEF) begin miscompares++; $display("FAIL busy_we_lo: got %h want not DEADBEEF", bus.lo); end
    wait_done(2, cyc, bok);
    vectors++; if (cyc !== LAT_SMALL) begin miscompares++; $display("FAIL ignore_latency: got %0d want %0d", cyc, LAT_SMALL); end
    vectors++; if (bus.hi !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL ignore_hi: got %h want FFFFFFFF", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFFFE0C) begin miscompares++; $display("FAIL ignore_lo: got %h want FFFFFE0C", bus.lo); end
    @(posedge clock); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL ignore_idle: busy got %b want 0", bus.busy); end
    bus.hilo_we = 1'b1; bus.hilo_sel = 1'b1; bus.hilo_wdata = 32'hCAFEF00D;
    @(posedge clock); #1;
    bus.hilo_we = 1'b0;
    vectors++; if (bus.hi !== 32'hCAFEF00D) begin miscompares++; $display("FAIL mthi: got %h want CAFEF00D", bus.hi); end
    vectors++; if (bus.lo !== 32'hFFFFFE0C) begin miscompares++; $display("FAIL mthi_lo: got %h want FFFFFE0C", bus.lo); end
  endtask

  task automatic test_reset_mid_op;
    int cyc; bit bok;
    start_op(2'b10, 32'd100, 32'd7);
    for (int i = 0; i < 9; i++) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL async_busy: got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL async_done: got %b want 0", bus.done); end
    vectors++; if (bus.hi !== 32'h0) begin miscompares++; $display("FAIL async_hi: got %h want 0", bus.hi); end
    vectors++; if (bus.lo !== 32'h0) begin miscompares++; $display("FAIL async_lo: got %h want 0", bus.lo); end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    start_op(2'b01, 32'd5, 32'd6);
    wait_done(0, cyc, bok);
    vectors++; if (cyc !== LAT_SMALL) begin miscompares++; $display("FAIL post_reset_latency: got %0d want %0d", cyc, LAT_SMALL); end
    vectors++; if (bus.lo !== 32'd30) begin miscompares++; $display("FAIL post_reset_lo: got %h want 1e", bus.lo); end
    vectors++; if (bus.hi !== 32'd0) begin miscompares++; $display("FAIL post_reset_hi: got %h want 0", bus.hi); end
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
    bus.hilo_we = 1'b0; bus.hilo_sel = 1'b0; bus.hilo_wdata = '0;
    test_reset();
    test_mult();
    test_back_to_back();
    test_div();
    test_div_zero();
    test_ignore_while_busy();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine with built-in HI/LO registers.
- Replaces the separate fixed-32-bit mult and div blocks and their HI/LO select muxes in the multicycle datapath.
- The control unit pulses start with an opcode; the engine latches the operands, iterates one bit per cycle, applies a sign fix-up, writes HI/LO and pulses done.
- Adds signed/unsigned modes, a direct HI/LO write port (MTHI/MTLO) and a divide-by-zero fast path.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO; minimum 4.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request an operation; sampled on the rising edge.
- op  input  2  operation select: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- a  input  WIDTH  multiplicand or dividend; latched at accept.
- b  input  WIDTH  multiplier or divisor; latched at accept.
- hilo_we  input  1  direct write strobe for HI/LO.
- hilo_sel  input  1  direct write target: 0 = LO, 1 = HI.
- hilo_wdata  input  WIDTH  direct write data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO hold the new result.
- div_zero  output  1  one-cycle pulse, coincident with done, on divide by zero.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous, active-low): FSM to IDLE; busy=0, done=0, div_zero=0, hi=0, lo=0. Applies at any time, including mid-operation; the partial result is discarded.
- FSM states: IDLE, MUL, DIV, FIX.
- Accept: start=1 at a rising edge while in IDLE (edge k). a, b and op are latched, operand magnitudes are taken for the signed ops, the iteration counter is loaded with WIDTH, and busy goes high after edge k.
- start while busy: ignored, and no state changes.
- MUL: shift-add on the magnitudes, one multiplier bit per cycle, for WIDTH cycles (edges k+1..k+WIDTH), then FIX.
- DIV: restoring division on the magnitudes, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX (edge k+WIDTH+1):
  - Negate the results as required.
  - Write HI/LO.
  - Set done=1, clear busy, return to IDLE.
- Fixed latency: done is high in the cycle after edge k+WIDTH+1, exactly WIDTH+1 cycles after accept (33 for WIDTH=32).
- done and div_zero are registered pulses, exactly one cycle wide.
- Back-to-back: a start during the done cycle is accepted (the FSM is already in IDLE).
- Multiply result: {hi,lo} = full 2*WIDTH-bit product. MULT is signed x signed; MULTU is unsigned.
- Divide result: lo = quotient, hi = remainder.
  - DIV: quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- Signed-divide overflow (most-negative / -1): lo = most-negative value, hi = 0.
- Divide by zero (op 10/11, b==0):
  - No iterations are performed.
  - done=1 and div_zero=1 after edge k+1.
  - hi/lo are unchanged; busy is high for one cycle only.
- Direct HI/LO write:
  - hilo_we in a cycle with busy=0 writes hilo_wdata to the register chosen by hilo_sel on that edge.
  - hilo_we while busy=1 is ignored.
  - hilo_we and an accepted start on the same edge: the direct write takes effect, and the later result overwrites it.
- hi/lo change only on a FIX write, a direct write, or reset.

Optional Feature:
- MULDIV_EARLY_EXIT_EN, when defined:
  - MUL iterations stop once the remaining unprocessed multiplier magnitude is zero.
  - Iteration count = (index of the MSB of |b|) + 1, or 0 when b==0.
  - done arrives (iterations+1) cycles after accept; e.g. 7*3 on WIDTH=32 completes in 3 cycles.
  - Results are identical to the fixed-latency build; DIV latency is unchanged.
- Without the macro: every MUL takes exactly WIDTH+1 cycles.

Test Plan:
- MULT with WIDTH=32, a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; done exactly 33 cycles after accept, for one cycle; busy=1 throughout.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; a new start in the done cycle is accepted.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 7/2 -> lo=3, hi=1; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Preload hi=0x1234, lo=0x5678 via hilo_we; DIV with b=0 -> done=1 and div_zero=1 one cycle after accept; hi/lo unchanged.
- Start MULT, then pulse start and hilo_we during busy -> both ignored, and the original result is correct; hilo_we with busy=0, hilo_sel=1, wdata=0xCAFEF00D -> hi=0xCAFEF00D on the next edge.
- Assert reset at the 10th cycle of a DIV -> busy, done, hi and lo become 0 immediately, without waiting for a clock edge; after release, a fresh MULTU 5*6 -> lo=30, hi=0.
